alu_writeback: RTL and testbench

Register-writeback stage directly downstream of the ALU. Holds the architectural accumulator and processor status register, commits each ALU result and flag vector under a per-operation flag mask, and issues a buffered memory write for read-modify-write shifts. Its `acc` and `status` outputs feed back as the ALU's accumulator and status inputs.

---
 rtl/alu_writeback.sv | 197 +++++++++++++++++++
 tb/tb_alu_writeback.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Writeback stage after the ALU: owns the accumulator and status register and
// buffers the single memory write produced by read-modify-write shifts.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for the next ALU result
//   ST_MEMWR | shift result held in the write buffer until memory accepts
module alu_writeback #(
  parameter int          ADDR_W  = 16,
  parameter logic [7:0]  RESET_P = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic              in_dst_mem,
  input  logic [7:0]        in_result,
  input  logic [7:0]        in_status,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [2:0]        flag_op,
  input  logic              p_load_valid,
  input  logic [7:0]        p_load_data,
  output logic [7:0]        acc,
  output logic [7:0]        status,
  output logic              mem_wr_valid,
  input  logic              mem_wr_ready,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MEMWR = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SBC = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_ORA = 4'd5;
  localparam logic [3:0] OP_BIT = 4'd6;
  localparam logic [3:0] OP_ASL = 4'd7;
  localparam logic [3:0] OP_LSR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_ROR = 4'd10;

  // Status layout: 7 C, 6 Z, 5 I, 4 D, 3 B, 2 reserved, 1 V, 0 N
  localparam int BIT_C = 7;
  localparam int BIT_I = 5;
  localparam int BIT_D = 4;
  localparam int BIT_R = 2;
  localparam int BIT_V = 1;

  localparam logic [7:0] MASK_ARITH = 8'b1100_0011;
  localparam logic [7:0] MASK_LOGIC = 8'b0100_0001;
  localparam logic [7:0] MASK_BIT   = 8'b0100_0011;
  localparam logic [7:0] MASK_SHIFT = 8'b1100_0001;

  localparam logic [2:0] FL_CLC = 3'd1;
  localparam logic [2:0] FL_SEC = 3'd2;
  localparam logic [2:0] FL_CLI = 3'd3;
  localparam logic [2:0] FL_SEI = 3'd4;
  localparam logic [2:0] FL_CLD = 3'd5;
  localparam logic [2:0] FL_SED = 3'd6;
  localparam logic [2:0] FL_CLV = 3'd7;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_wr_valid_q, mem_wr_valid_d;
  logic [ADDR_W-1:0]   mem_wr_addr_q, mem_wr_addr_d;
  logic [7:0]          mem_wr_data_q, mem_wr_data_d;
  logic [7:0]          acc_q, acc_d;
  logic [7:0]          status_q, status_d;

  logic                accept;
  logic [7:0]          flag_mask;
  logic                acc_we;
  logic                mem_shift;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    flag_mask = 8'h00;
    acc_we    = 1'b0;
    mem_shift = 1'b0;
    if (accept) begin
      case (in_op)
        OP_ADD, OP_ADC, OP_SBC: begin
          flag_mask = MASK_ARITH;
          acc_we    = 1'b1;
        end
        OP_AND, OP_EOR, OP_ORA: begin
          flag_mask = MASK_LOGIC;
          acc_we    = 1'b1;
        end
        OP_BIT: begin
          flag_mask = MASK_BIT;
        end
        OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
          flag_mask = MASK_SHIFT;
          acc_we    = !in_dst_mem;
          mem_shift = in_dst_mem;
        end
        default: begin
          flag_mask = 8'h00;
        end
      endcase
    end
  end

  // Priority: ALU mask first, then flag_op, then full status load.
  always_comb begin
    status_d = (status_q & ~flag_mask) | (in_status & flag_mask);
    case (flag_op)
      FL_CLC:  status_d[BIT_C] = 1'b0;
      FL_SEC:  status_d[BIT_C] = 1'b1;
      FL_CLI:  status_d[BIT_I] = 1'b0;
      FL_SEI:  status_d[BIT_I] = 1'b1;
      FL_CLD:  status_d[BIT_D] = 1'b0;
      FL_SED:  status_d[BIT_D] = 1'b1;
      FL_CLV:  status_d[BIT_V] = 1'b0;
      default: ;
    endcase
    if (p_load_valid) begin
      status_d = p_load_data;
    end
    status_d[BIT_R] = 1'b0;
  end

  always_comb begin
    acc_d = acc_q;
    if (acc_we) begin
      acc_d = in_result;
    end
  end

  always_comb begin
    state_d        = state_q;
    in_ready_d     = in_ready_q;
    mem_wr_valid_d = mem_wr_valid_q;
    mem_wr_addr_d  = mem_wr_addr_q;
    mem_wr_data_d  = mem_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_shift) begin
          state_d        = ST_MEMWR;
          in_ready_d     = 1'b0;
          mem_wr_valid_d = 1'b1;
          mem_wr_addr_d  = in_addr;
          mem_wr_data_d  = in_result;
        end
      end
      ST_MEMWR: begin
        if (mem_wr_ready) begin
          state_d        = ST_IDLE;
          in_ready_d     = 1'b1;
          mem_wr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d        = ST_IDLE;
        in_ready_d     = 1'b1;
        mem_wr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      in_ready_q     <= 1'b1;
      mem_wr_valid_q <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= 8'h00;
      acc_q          <= 8'h00;
      status_q       <= RESET_P;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      mem_wr_valid_q <= mem_wr_valid_d;
      mem_wr_addr_q  <= mem_wr_addr_d;
      mem_wr_data_q  <= mem_wr_data_d;
      acc_q          <= acc_d;
      status_q       <= status_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_wr_valid = mem_wr_valid_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign acc          = acc_q;
  assign status       = status_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: hand-computed accumulator, status and
// write-buffer values across register ops, flag ops, status loads and memory shifts.
module tb_alu_writeback;

  localparam int ADDR_W = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic              in_dst_mem;
  logic [7:0]        in_result;
  logic [7:0]        in_status;
  logic [ADDR_W-1:0] in_addr;
  logic [2:0]        flag_op;
  logic              p_load_valid;
  logic [7:0]        p_load_data;
  logic [7:0]        acc;
  logic [7:0]        status;
  logic              mem_wr_valid;
  logic              mem_wr_ready;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [7:0]        mem_wr_data;

  int n_tests;
  int n_fail;

  alu_writeback #(.ADDR_W(ADDR_W), .RESET_P(8'h20)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_dst_mem   (in_dst_mem),
    .in_result    (in_result),
    .in_status    (in_status),
    .in_addr      (in_addr),
    .flag_op      (flag_op),
    .p_load_valid (p_load_valid),
    .p_load_data  (p_load_data),
    .acc          (acc),
    .status       (status),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle just past the rising edge.
  task automatic cyc(input logic v, input logic [3:0] op, input logic dm,
                     input logic [7:0] res, input logic [7:0] st,
                     input logic [ADDR_W-1:0] addr, input logic [2:0] fop,
                     input logic pl, input logic [7:0] pd);
    @(negedge clk);
    in_valid     = v;
    in_op        = op;
    in_dst_mem   = dm;
    in_result    = res;
    in_status    = st;
    in_addr      = addr;
    flag_op      = fop;
    p_load_valid = pl;
    p_load_data  = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 1'b0, 8'h00, 8'h00, '0, 3'd0, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [2:0] fop;
    logic [7:0] exp_status;
  } flag_vec_t;

  flag_vec_t fvec[8];

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_op        = 4'd0;
    in_dst_mem   = 1'b0;
    in_result    = 8'h00;
    in_status    = 8'h00;
    in_addr      = '0;
    flag_op      = 3'd0;
    p_load_valid = 1'b0;
    p_load_data  = 8'h00;
    mem_wr_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", {24'h0, acc}, 32'h00);
    chk("rst_status", {24'h0, status}, 32'h20);
    chk("rst_wr_valid", {31'h0, mem_wr_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    idle();
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    chk("post_rst_acc", {24'h0, acc}, 32'h00);
    chk("post_rst_status", {24'h0, status}, 32'h20);
    chk("post_rst_wr_addr", {16'h0, mem_wr_addr}, 32'h0);
    chk("post_rst_wr_data", {24'h0, mem_wr_data}, 32'h00);

    // ADC: C,V,N from ALU, I kept
    cyc(1'b1, 4'd1, 1'b0, 8'h80, 8'h83, '0, 3'd0, 1'b0, 8'h00);
    chk("adc_acc", {24'h0, acc}, 32'h80);
    chk("adc_status", {24'h0, status}, 32'hA3);

    // status load with reserved bit forced low
    cyc(1'b0, 4'd0, 1'b0, 8'h00, 8'h00, '0, 3'd0, 1'b1, 8'h24);
    chk("pload_status", {24'h0, status}, 32'h20);

    cyc(1'b1, 4'd5, 1'b0, 8'h5A, 8'h00, '0, 3'd0, 1'b0, 8'h00);
    chk("ora_acc", {24'h0, acc}, 32'h5A);
    chk("ora_status", {24'h0, status}, 32'h20);

    cyc(1'b1, 4'd6, 1'b0, 8'h00, 8'h42, '0, 3'd0, 1'b0, 8'h00);
    chk("bit_acc", {24'h0, acc}, 32'h5A);
    chk("bit_status", {24'h0, status}, 32'h62);

    // flag ops alone, chained from 62
    fvec[0] = '{3'd2, 8'hE2};
    fvec[1] = '{3'd3, 8'hC2};
    fvec[2] = '{3'd6, 8'hD2};
    fvec[3] = '{3'd5, 8'hC2};
    fvec[4] = '{3'd7, 8'hC0};
    fvec[5] = '{3'd1, 8'h40};
    fvec[6] = '{3'd4, 8'h60};
    fvec[7] = '{3'd0, 8'h60};
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'd0, 1'b0, 8'h00, 8'h00, '0, fvec[i].fop, 1'b0, 8'h00);
      chk($sformatf("flag_op%0d", fvec[i].fop), {24'h0, status}, {24'h0, fvec[i].exp_status});
    end

    // SEC overrides the ALU carry of the same cycle
    cyc(1'b1, 4'd0, 1'b0, 8'h11, 8'h00, '0, 3'd2, 1'b0, 8'h00);
    chk("sec_add_acc", {24'h0, acc}, 32'h11);
    chk("sec_add_status", {24'h0, status}, 32'hA0);

    // status load overrides both
    cyc(1'b1, 4'd0, 1'b0, 8'h22, 8'h00, '0, 3'd2, 1'b1, 8'hFF);
    chk("pload_over_acc", {24'h0, acc}, 32'h22);
    chk("pload_over_status", {24'h0, status}, 32'hFB);

    // undefined op: no state change
    cyc(1'b1, 4'd12, 1'b0, 8'h99, 8'h00, '0, 3'd0, 1'b0, 8'h00);
    chk("op12_acc", {24'h0, acc}, 32'h22);
    chk("op12_status", {24'h0, status}, 32'hFB);

    // in_dst_mem ignored on non-shift; mem_wr_ready ignored while idle
    mem_wr_ready = 1'b1;
    cyc(1'b1, 4'd3, 1'b1, 8'h0F, 8'h00, 16'h0300, 3'd0, 1'b0, 8'h00);
    chk("and_dm_acc", {24'h0, acc}, 32'h0F);
    chk("and_dm_status", {24'h0, status}, 32'hBA);
    chk("and_dm_wr_valid", {31'h0, mem_wr_valid}, 32'h0);
    chk("and_dm_ready", {31'h0, in_ready}, 32'h1);

    // register-destination shift
    cyc(1'b1, 4'd8, 1'b0, 8'h2D, 8'h80, '0, 3'd0, 1'b0, 8'h00);
    chk("lsr_acc", {24'h0, acc}, 32'h2D);
    chk("lsr_status", {24'h0, status}, 32'hBA);
    cyc(1'b1, 4'd3, 1'b0, 8'h0F, 8'h00, '0, 3'd0, 1'b0, 8'h00);
    chk("and_acc", {24'h0, acc}, 32'h0F);

    // memory-destination ASL, write held off for 3 cycles
    mem_wr_ready = 1'b0;
    cyc(1'b1, 4'd7, 1'b1, 8'h54, 8'h01, 16'h0210, 3'd0, 1'b0, 8'h00);
    chk("asl_wr_valid", {31'h0, mem_wr_valid}, 32'h1);
    chk("asl_ready", {31'h0, in_ready}, 32'h0);
    chk("asl_wr_addr", {16'h0, mem_wr_addr}, 32'h0210);
    chk("asl_wr_data", {24'h0, mem_wr_data}, 32'h54);
    chk("asl_acc", {24'h0, acc}, 32'h0F);
    chk("asl_status", {24'h0, status}, 32'h3B);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'd0, 1'b0, 8'h77, 8'h00, 16'h0555, 3'd0, 1'b0, 8'h00);
      chk("hold_wr_valid", {31'h0, mem_wr_valid}, 32'h1);
      chk("hold_ready", {31'h0, in_ready}, 32'h0);
      chk("hold_wr_addr", {16'h0, mem_wr_addr}, 32'h0210);
      chk("hold_wr_data", {24'h0, mem_wr_data}, 32'h54);
      chk("hold_acc", {24'h0, acc}, 32'h0F);
      chk("hold_status", {24'h0, status}, 32'h3B);
    end
    @(negedge clk);
    mem_wr_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("wr_done_valid", {31'h0, mem_wr_valid}, 32'h0);
    chk("wr_done_ready", {31'h0, in_ready}, 32'h1);
    chk("wr_done_acc", {24'h0, acc}, 32'h0F);
    cyc(1'b1, 4'd0, 1'b0, 8'h77, 8'h00, '0, 3'd0, 1'b0, 8'h00);
    chk("b2b_add_acc", {24'h0, acc}, 32'h77);
    chk("b2b_add_status", {24'h0, status}, 32'h38);

    // async reset while a write is pending
    mem_wr_ready = 1'b0;
    cyc(1'b1, 4'd10, 1'b1, 8'hAA, 8'h00, 16'h1234, 3'd0, 1'b0, 8'h00);
    chk("ror_wr_valid", {31'h0, mem_wr_valid}, 32'h1);
    chk("ror_wr_addr", {16'h0, mem_wr_addr}, 32'h1234);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_wr_valid", {31'h0, mem_wr_valid}, 32'h0);
    chk("async_rst_status", {24'h0, status}, 32'h20);
    chk("async_rst_acc", {24'h0, acc}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    mem_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("after_rst_wr_valid", {31'h0, mem_wr_valid}, 32'h0);
      chk("after_rst_ready", {31'h0, in_ready}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
